// File: rtl/ysyx_25040129_pkg.sv
// Purpose: shared types and constants for the instruction fetch unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ysyx_25040129_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h8000_0000;

    // addi x0, x0, 0
    localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } ifu_state_e;

    // Fetch addresses are always word aligned.
    function automatic logic [XLEN-1:0] pc_align(input logic [XLEN-1:0] pc);
        return {pc[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/ysyx_25040129_pc_reg.sv
// Purpose: program counter register with load enable.
// Latency: 1 cycle from d_i/en_i to q_o.
// Backpressure: none; holds its value while en_i is low.
module ysyx_25040129_pc_reg #(
    parameter int unsigned WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] pc_q;

    // Synchronous reset to the boot address, otherwise load when enabled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q <= RESET_VAL;
        end else if (en_i) begin
            pc_q <= d_i;
        end
    end

    assign q_o = pc_q;

endmodule

// File: rtl/ysyx_25040129_ifu.sv
// Purpose: instruction fetch unit, one outstanding fetch, redirect has top priority.
// Latency: request accepted in N, response N+1, inst_valid N+2 (one instruction per 3 cycles).
// Backpressure: holds inst/inst_pc stable while inst_ready is low; stalls fetching meanwhile.
module ysyx_25040129_ifu
    import ysyx_25040129_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc
);

    ifu_state_e      state_q, state_d;
    logic            kill_q, kill_d;
    logic [XLEN-1:0] inst_q, inst_d;
    logic [XLEN-1:0] inst_pc_q, inst_pc_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            pc_en;
    logic            req_vld;
    logic            inst_vld;

    ysyx_25040129_pc_reg #(
        .WIDTH     (XLEN),
        .RESET_VAL (pc_align(RESET_PC))
    ) u_pc_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (pc_en),
        .d_i   (pc_d),
        .q_o   (pc_q)
    );

    // Next-state, pc update and handshake outputs; redirect overrides everything.
    always_comb begin
        state_d   = state_q;
        kill_d    = kill_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        pc_en     = 1'b0;
        pc_d      = pc_q;
        req_vld   = 1'b0;
        inst_vld  = 1'b0;

        if (redirect_valid) begin
            pc_en = 1'b1;
            pc_d  = pc_align(redirect_pc);
        end

        case (state_q)
            ST_REQ: begin
                req_vld = !redirect_valid;
                if (req_vld && imem_req_ready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem_rsp_valid) begin
                    // The outstanding fetch returns; a killed or redirected one is dropped.
                    kill_d = 1'b0;
                    if (!kill_q && !redirect_valid) begin
                        inst_d    = imem_rdata;
                        inst_pc_d = pc_q;
                        state_d   = ST_HOLD;
                    end else begin
                        state_d = ST_REQ;
                    end
                end else if (redirect_valid) begin
                    // Stay until the stale response drains so only one fetch is ever in flight.
                    kill_d = 1'b1;
                end
            end
            ST_HOLD: begin
                inst_vld = !redirect_valid;
                if (redirect_valid) begin
                    state_d = ST_REQ;
                end else if (inst_ready) begin
                    pc_en   = 1'b1;
                    pc_d    = pc_q + 32'd4;
                    state_d = ST_REQ;
                end
            end
            default: begin
                state_d = ST_REQ;
            end
        endcase
    end

    // State, kill flag and the instruction buffer with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_REQ;
            kill_q    <= 1'b0;
            inst_q    <= NOP;
            inst_pc_q <= '0;
        end else begin
            state_q   <= state_d;
            kill_q    <= kill_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
        end
    end

    assign imem_req_valid = rst_n & req_vld;
    assign inst_valid     = rst_n & inst_vld;
    assign imem_addr      = pc_align(pc_q);
    assign inst           = inst_q;
    assign inst_pc        = inst_pc_q;

endmodule

// File: doc/ysyx_25040129_ifu.md
YSYX_25040129_IFU -- requirements
Module: ysyx_25040129_IFU

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h8000_0000: the first fetch address after reset.
REQ-002 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, synchronous, active-low.
REQ-004 SHALL have port imem_req_valid, output, 1: fetch request valid.
REQ-005 SHALL have port imem_req_ready, input, 1: memory accepts the request.
REQ-006 SHALL have port imem_addr, output, 32: fetch address.
REQ-007 SHALL have port imem_rsp_valid, input, 1: fetch response valid.
REQ-008 SHALL have port imem_rdata, input, 32: fetched instruction word.
REQ-009 SHALL have port inst_valid, output, 1: instruction available to the decoder.
REQ-010 SHALL have port inst_ready, input, 1: decoder/downstream accepts the instruction.
REQ-011 SHALL have port inst, output, 32: instruction word fed to the decoder.
REQ-012 SHALL have port inst_pc, output, 32: PC of inst.
REQ-013 SHALL have port redirect_valid, input, 1: branch/jump/trap/mret redirect request.
REQ-014 SHALL have port redirect_pc, input, 32: redirect target.

Function
REQ-015 SHALL implement the FSM states REQ, WAIT and HOLD, with one outstanding fetch at most.
REQ-016 In REQ: imem_req_valid = !redirect_valid, imem_addr = pc; on a request handshake, go to WAIT.
REQ-017 In WAIT: on imem_rsp_valid with no kill pending and no redirect_valid, latch imem_rdata into inst and pc into inst_pc, then go to HOLD.
REQ-018 In HOLD: inst_valid = !redirect_valid; on inst_valid && inst_ready, set pc <= pc+4 and go to REQ.
REQ-019 pc+4 SHALL wrap modulo 2^32; 32'hFFFF_FFFC is followed by 32'h0000_0000.
REQ-020 Redirect SHALL have the highest priority: pc <= {redirect_pc[31:2],2'b00} in any state.
REQ-021 Redirect in REQ: stay in REQ; no request is issued that cycle; the next request uses the target.
REQ-022 Redirect in WAIT without imem_rsp_valid: set kill; the next response is discarded; kill clears; go to REQ.
REQ-023 Redirect in WAIT coinciding with imem_rsp_valid: discard the response and go to REQ.
REQ-024 Redirect in HOLD: drop the held instruction and go to REQ; inst_ready is ignored that cycle.
REQ-025 imem_rsp_valid outside WAIT SHALL be ignored.
REQ-026 While inst_valid && !inst_ready, inst and inst_pc SHALL hold stable.
REQ-027 Minimum latency: request accepted in cycle N, response in N+1, inst_valid in N+2.
REQ-028 Peak throughput: one instruction per 3 cycles.
REQ-029 imem_addr[1:0] SHALL always be 2'b00.

Reset
REQ-030 While rst_n=0 at a clock edge: state=REQ, pc=RESET_PC, kill=0, inst=32'h0000_0013, inst_pc=0.
REQ-031 During reset cycles, imem_req_valid=0 and inst_valid=0.
REQ-032 Reset mid-operation SHALL abandon any fetch in flight. The memory shares rst_n, so no stale response follows.
REQ-033 The first request SHALL issue in the first cycle with rst_n=1, at address RESET_PC.

Structure
REQ-034 Shared package ysyx_25040129_pkg SHALL hold the FSM state enum, the RESET_PC default, the NOP constant 32'h0000_0013 and XLEN=32.
REQ-035 One sub-module SHALL be used: ysyx_25040129_pc_reg, a 32-bit register with synchronous active-low reset value and an enable.
REQ-036 The block SHALL connect to the decoder via inst/inst_valid/inst_ready and to the execute/trap unit via redirect.

Verification
REQ-037 Reset release, memory always ready, inst_ready=1 -> requests at 0x80000000, 0x80000004, 0x80000008, with inst_valid every 3rd cycle.
REQ-038 inst_ready held 0 for 5 cycles in HOLD -> inst and inst_pc unchanged, no new request; release -> next request at pc+4.
REQ-039 Redirect to 0x80000103 while in WAIT, response delayed 3 cycles -> response dropped; next request at 0x80000100; inst_valid never asserted for the old fetch.
REQ-040 Redirect coinciding with inst_valid && inst_ready in HOLD -> no handshake, pc=target, next request to target.
REQ-041 pc=0xFFFFFFFC accepted -> next request at 0x00000000.
REQ-042 rst_n=0 asserted in WAIT -> after release, request at RESET_PC; inst_valid stays 0 until a new response arrives.
